// File: rtl/trilat_solver.sv
// trilat_solver: intersects circles B and C using a bit-serial square root.
// Optionally keeps only the intersection point closest to reference circle A.
module trilat_solver #(
    parameter int N  = 8,
    parameter int OW = N + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [N-1:0]  in_xA,
    input  logic signed [N-1:0]  in_yA,
    input  logic signed [N-1:0]  in_xB,
    input  logic signed [N-1:0]  in_yB,
    input  logic signed [N-1:0]  in_xC,
    input  logic signed [N-1:0]  in_yC,
    input  logic signed [N:0]    in_rA,
    input  logic signed [N:0]    in_rB,
    input  logic signed [N:0]    in_rC,
    input  logic                 in_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_x1,
    output logic signed [OW-1:0] out_y1,
    output logic signed [OW-1:0] out_x2,
    output logic signed [OW-1:0] out_y2,
    output logic [1:0]           out_status
);
    localparam int WW = 6*N + 14;
    localparam int M  = 3*N + 7;
    localparam int RW = WW / 2;
    localparam int CW = $clog2(M + 1);
    localparam int EW = 2*WW + 4;

    typedef enum logic [2:0] {IDLE, CALC, SQRT, SOLVE, SEL, DONE} state_t;
    state_t state, state_nx;

    logic signed [N-1:0]  xa, ya, xb, yb, xc, yc;
    logic signed [N:0]    ra, rb, rc;
    logic                 mode;
    logic signed [WW-1:0] w2_q;
    logic [RW-1:0]        root;
    logic [RW+2:0]        rem;
    logic [CW-1:0]        cnt;
    logic signed [WW-1:0] x1_q, y1_q, x2_q, y2_q;

    // CALC: exact products in full width
    logic signed [WW-1:0] xb_w, yb_w, xc_w, yc_w, rb_w, rc_w;
    logic signed [WW-1:0] p, q, p2, pq2, t, qt, s, u, w2_c;
    always_comb begin
        xb_w = WW'(xb);
        yb_w = WW'(yb);
        xc_w = WW'(xc);
        yc_w = WW'(yc);
        rb_w = WW'(rb);
        rc_w = WW'(rc);
        p    = xc_w - xb_w;
        q    = yb_w - yc_w;
        p2   = p * p;
        pq2  = p2 + q * q;
        t    = rb_w * rb_w - rc_w * rc_w + xc_w * xc_w - xb_w * xb_w
             + yc_w * yc_w - yb_w * yb_w;
        qt   = q * t;
        s    = ((p2 * yb_w * yb_w) <<< 2) + t * t - ((p * t * xb_w) <<< 2)
             + ((p2 * xb_w * xb_w) <<< 2) - ((p2 * rb_w * rb_w) <<< 2);
        u    = qt - ((p2 * yb_w) <<< 1) - ((p * q * xb_w) <<< 1);
        w2_c = u * u - s * pq2;
    end

    // SQRT: radicand pairs are taken straight from w2_q, MSB pair first (cnt counts down)
    logic [1:0]    pair;
    logic [RW+2:0] rem_sh, trial;
    logic          fits;
    always_comb begin
        pair   = w2_q[WW-1] ? 2'b00 : w2_q[{cnt, 1'b0} +: 2];
        rem_sh = (rem << 2) | {{(RW+1){1'b0}}, pair};
        trial  = {1'b0, root, 2'b01};
        fits   = (rem_sh >= trial);
    end

    // SOLVE
    logic                 degen;
    logic signed [WW-1:0] w_half, h, den_y, den_x, y1_c, y2_c, x1_c, x2_c;
    always_comb begin
        degen  = (p == '0);
        w_half = WW'(root >> 1);
        h      = p * q * xb_w + p2 * yb_w - (qt >>> 1);
        den_y  = degen ? WW'(1) : pq2;
        den_x  = degen ? WW'(1) : (p <<< 1);
        y1_c   = (h + w_half) / den_y;
        y2_c   = (h - w_half) / den_y;
        x1_c   = (((q * y1_c) <<< 1) + t) / den_x;
        x2_c   = (((q * y2_c) <<< 1) + t) / den_x;
    end

    function automatic logic signed [EW-1:0] err(
        input logic signed [WW-1:0] x,
        input logic signed [WW-1:0] y,
        input logic signed [N-1:0]  cx,
        input logic signed [N-1:0]  cy,
        input logic signed [N:0]    r
    );
        logic signed [EW-1:0] dx, dy, e;
        dx = EW'(x) - EW'(cx);
        dy = EW'(y) - EW'(cy);
        e  = dx * dx + dy * dy - EW'(r) * EW'(r);
        return e[EW-1] ? -e : e;
    endfunction

    function automatic logic signed [OW-1:0] sat(input logic signed [WW-1:0] v);
        if (&v[WW-1:OW-1] || ~|v[WW-1:OW-1])
            return v[OW-1:0];
        return v[WW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
    endfunction

    // SEL
    logic signed [EW-1:0] e1, e2;
    logic                 pick2;
    logic signed [WW-1:0] selx1, sely1, selx2, sely2;
    logic [1:0]           status_c;
    logic signed [OW-1:0] sx1, sy1, sx2, sy2;
    always_comb begin
        e1       = err(x1_q, y1_q, xa, ya, ra);
        e2       = err(x2_q, y2_q, xa, ya, ra);
        pick2    = mode && (e2 < e1);
        selx1    = pick2 ? x2_q : x1_q;
        sely1    = pick2 ? y2_q : y1_q;
        selx2    = mode ? selx1 : x2_q;
        sely2    = mode ? sely1 : y2_q;
        status_c = degen ? 2'b10 : (w2_q[WW-1] ? 2'b01 : 2'b00);
        sx1      = '0;
        sy1      = '0;
        sx2      = '0;
        sy2      = '0;
        if (status_c == 2'b00) begin
            sx1 = sat(selx1);
            sy1 = sat(sely1);
            sx2 = sat(selx2);
            sy2 = sat(sely2);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = CALC;
            CALC:    state_nx = SQRT;
            SQRT:    if (cnt == '0) state_nx = SOLVE;
            SOLVE:   state_nx = SEL;
            SEL:     state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {xa, ya, xb, yb, xc, yc} <= '0;
            {ra, rb, rc}             <= '0;
            mode                     <= 1'b0;
            w2_q                     <= '0;
            root                     <= '0;
            rem                      <= '0;
            cnt                      <= '0;
            {x1_q, y1_q, x2_q, y2_q} <= '0;
            {out_x1, out_y1}         <= '0;
            {out_x2, out_y2}         <= '0;
            out_status               <= 2'b00;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    xa   <= in_xA;
                    ya   <= in_yA;
                    xb   <= in_xB;
                    yb   <= in_yB;
                    xc   <= in_xC;
                    yc   <= in_yC;
                    ra   <= in_rA;
                    rb   <= in_rB;
                    rc   <= in_rC;
                    mode <= in_mode;
                end
                CALC: begin
                    w2_q <= w2_c;
                    root <= '0;
                    rem  <= '0;
                    cnt  <= CW'(M - 1);
                end
                SQRT: begin
                    rem  <= fits ? rem_sh - trial : rem_sh;
                    root <= {root[RW-2:0], fits};
                    cnt  <= cnt - CW'(1);
                end
                SOLVE: begin
                    x1_q <= degen ? '0 : x1_c;
                    y1_q <= degen ? '0 : y1_c;
                    x2_q <= degen ? '0 : x2_c;
                    y2_q <= degen ? '0 : y2_c;
                end
                SEL: begin
                    out_x1     <= sx1;
                    out_y1     <= sy1;
                    out_x2     <= sx2;
                    out_y2     <= sy2;
                    out_status <= status_c;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_trilat_solver.sv
// Directed bench for trilat_solver: geometry cases, latency, back-pressure,
// back-to-back throughput and mid-job reset.
module tb_trilat_solver;
    localparam int N  = 8;
    localparam int OW = N + 4;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, in_ready, in_mode, out_valid, out_ready;
    logic signed [N-1:0]  in_xA, in_yA, in_xB, in_yB, in_xC, in_yC;
    logic signed [N:0]    in_rA, in_rB, in_rC;
    logic signed [OW-1:0] out_x1, out_y1, out_x2, out_y2;
    logic [1:0]           out_status;

    int checks   = 0;
    int failures = 0;

    trilat_solver #(.N(N), .OW(OW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_xA(in_xA), .in_yA(in_yA), .in_xB(in_xB), .in_yB(in_yB),
        .in_xC(in_xC), .in_yC(in_yC),
        .in_rA(in_rA), .in_rB(in_rB), .in_rC(in_rC),
        .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_x1(out_x1), .out_y1(out_y1), .out_x2(out_x2), .out_y2(out_y2),
        .out_status(out_status)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic set_job(input int xa, ya, ra, xb, yb, rb, xc, yc, rc, input logic mode);
        in_xA = N'(xa); in_yA = N'(ya); in_rA = (N+1)'(ra);
        in_xB = N'(xb); in_yB = N'(yb); in_rB = (N+1)'(rb);
        in_xC = N'(xc); in_yC = N'(yc); in_rC = (N+1)'(rc);
        in_mode = mode;
    endtask

    // returns 1 time unit after the accepting edge
    task automatic offer();
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handoff();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        set_job(0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        checks++;
        if ({out_x1, out_y1, out_x2, out_y2, out_status} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: (%0d,%0d) (%0d,%0d) st=%b, want zeros st=00",
                     out_x1, out_y1, out_x2, out_y2, out_status);
        end
        checks++;
        if (dut.root !== '0) begin
            failures++;
            $display("FAIL reset_root: root=%0d, want 0", dut.root);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_mode0();
        int lat;
        set_job(3, 5, 1, 0, 0, 5, 6, 0, 5, 1'b0);
        offer();
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL mode0_accept: in_ready=%b, want 0", in_ready);
        end
        set_job(-7, -7, 9, 1, 2, 3, 4, 5, 6, 1'b1);
        wait_done(lat);
        checks++;
        if (lat !== 34) begin
            failures++;
            $display("FAIL mode0_latency: got %0d edges, want 34", lat);
        end
        checks++;
        if ({out_x1, out_y1, out_x2, out_y2, out_status} !== {12'sd3, 12'sd4, 12'sd3, -12'sd4, 2'b00}) begin
            failures++;
            $display("FAIL mode0_points: (%0d,%0d) (%0d,%0d) st=%b, want (3,4) (3,-4) st=00",
                     out_x1, out_y1, out_x2, out_y2, out_status);
        end
        checks++;
        if (dut.w2_q !== 62'sd82944) begin
            failures++;
            $display("FAIL mode0_w2: got %0d, want 82944", dut.w2_q);
        end
        checks++;
        if (dut.root !== 31'd288) begin
            failures++;
            $display("FAIL mode0_root: got %0d, want 288", dut.root);
        end
        handoff();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            {out_x1, out_y1, out_x2, out_y2, out_status} !== {12'sd3, 12'sd4, 12'sd3, -12'sd4, 2'b00}) begin
            failures++;
            $display("FAIL mode0_retain: out_valid=%b in_ready=%b (%0d,%0d) (%0d,%0d) st=%b, want 0 1 (3,4) (3,-4) st=00",
                     out_valid, in_ready, out_x1, out_y1, out_x2, out_y2, out_status);
        end
    endtask

    task automatic test_mode1();
        int lat;
        set_job(3, 5, 1, 0, 0, 5, 6, 0, 5, 1'b1);
        offer();
        wait_done(lat);
        checks++;
        if (lat !== 34 || {out_x1, out_y1, out_x2, out_y2, out_status} !== {12'sd3, 12'sd4, 12'sd3, 12'sd4, 2'b00}) begin
            failures++;
            $display("FAIL mode1_upper: lat=%0d (%0d,%0d) (%0d,%0d) st=%b, want 34 (3,4) (3,4) st=00",
                     lat, out_x1, out_y1, out_x2, out_y2, out_status);
        end
        handoff();
        set_job(3, -5, 1, 0, 0, 5, 6, 0, 5, 1'b1);
        offer();
        wait_done(lat);
        checks++;
        if (lat !== 34 || {out_x1, out_y1, out_x2, out_y2, out_status} !== {12'sd3, -12'sd4, 12'sd3, -12'sd4, 2'b00}) begin
            failures++;
            $display("FAIL mode1_lower: lat=%0d (%0d,%0d) (%0d,%0d) st=%b, want 34 (3,-4) (3,-4) st=00",
                     lat, out_x1, out_y1, out_x2, out_y2, out_status);
        end
        handoff();
    endtask

    task automatic test_no_intersect();
        int lat;
        set_job(3, 5, 1, 0, 0, 2, 10, 0, 2, 1'b0);
        offer();
        wait_done(lat);
        checks++;
        if (lat !== 34) begin
            failures++;
            $display("FAIL nointer_latency: got %0d edges, want 34", lat);
        end
        checks++;
        if ({out_x1, out_y1, out_x2, out_y2, out_status} !== {48'd0, 2'b01}) begin
            failures++;
            $display("FAIL nointer_result: (%0d,%0d) (%0d,%0d) st=%b, want zeros st=01",
                     out_x1, out_y1, out_x2, out_y2, out_status);
        end
        handoff();
    endtask

    task automatic test_tangent();
        int lat;
        set_job(3, 5, 1, 0, 0, 3, 6, 0, 3, 1'b0);
        offer();
        wait_done(lat);
        checks++;
        if (lat !== 34 || {out_x1, out_y1, out_x2, out_y2, out_status} !== {12'sd3, 12'sd0, 12'sd3, 12'sd0, 2'b00}) begin
            failures++;
            $display("FAIL tangent_points: lat=%0d (%0d,%0d) (%0d,%0d) st=%b, want 34 (3,0) (3,0) st=00",
                     lat, out_x1, out_y1, out_x2, out_y2, out_status);
        end
        handoff();
    endtask

    task automatic test_degenerate();
        int lat;
        set_job(3, 5, 1, 0, 0, 5, 0, 6, 5, 1'b0);
        offer();
        wait_done(lat);
        checks++;
        if (lat !== 34 || {out_x1, out_y1, out_x2, out_y2, out_status} !== {48'd0, 2'b10}) begin
            failures++;
            $display("FAIL degenerate_result: lat=%0d (%0d,%0d) (%0d,%0d) st=%b, want 34 zeros st=10",
                     lat, out_x1, out_y1, out_x2, out_y2, out_status);
        end
        handoff();
    endtask

    task automatic test_back_pressure();
        int lat;
        logic held_ok;
        logic [4*OW+1:0] saved;
        out_ready = 1'b0;
        set_job(3, 5, 1, 0, 0, 5, 6, 0, 5, 1'b0);
        offer();
        wait_done(lat);
        saved = {out_x1, out_y1, out_x2, out_y2, out_status};
        checks++;
        if (saved !== {12'sd3, 12'sd4, 12'sd3, -12'sd4, 2'b00}) begin
            failures++;
            $display("FAIL bp_result: got %h, want (3,4) (3,-4) st=00", saved);
        end
        set_job(3, 5, 1, 0, 0, 3, 6, 0, 3, 1'b0);
        @(negedge clk);
        in_valid = 1'b1;
        held_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
                {out_x1, out_y1, out_x2, out_y2, out_status} !== saved)
                held_ok = 1'b0;
        end
        checks++;
        if (held_ok !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold: outputs or handshake moved while stalled (held_ok=%b), want stable", held_ok);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_handoff: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_next_accept: in_ready=%b, want 0", in_ready);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        wait_done(lat);
        checks++;
        if (lat !== 34 || {out_x1, out_y1, out_x2, out_y2, out_status} !== {12'sd3, 12'sd0, 12'sd3, 12'sd0, 2'b00}) begin
            failures++;
            $display("FAIL bp_next_job: lat=%0d (%0d,%0d) (%0d,%0d) st=%b, want 34 (3,0) (3,0) st=00",
                     lat, out_x1, out_y1, out_x2, out_y2, out_status);
        end
        handoff();
    endtask

    task automatic test_back_to_back();
        int rise1, rise2;
        logic rdy35, rdy36;
        logic [4*OW+1:0] res1, res2;
        rise1 = -1; rise2 = -1; rdy35 = 1'bx; rdy36 = 1'bx;
        res1 = '0; res2 = '0;
        out_ready = 1'b1;
        set_job(3, -5, 1, 0, 0, 5, 6, 0, 5, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (k == 20) set_job(3, 5, 1, 0, 0, 3, 6, 0, 3, 1'b0);
            if (k == 35) rdy35 = in_ready;
            if (k == 36) rdy36 = in_ready;
            if (out_valid === 1'b1 && rise1 < 0) begin
                rise1 = k;
                res1 = {out_x1, out_y1, out_x2, out_y2, out_status};
            end else if (out_valid === 1'b1 && rise2 < 0) begin
                rise2 = k;
                res2 = {out_x1, out_y1, out_x2, out_y2, out_status};
            end
            if (k == 70) in_valid = 1'b0;
        end
        out_ready = 1'b0;
        checks++;
        if (rise1 !== 34 || rise2 !== 70) begin
            failures++;
            $display("FAIL b2b_timing: done at edges %0d and %0d, want 34 and 70", rise1, rise2);
        end
        checks++;
        if (rdy35 !== 1'b1 || rdy36 !== 1'b0) begin
            failures++;
            $display("FAIL b2b_reaccept: in_ready at 35=%b 36=%b, want 1 0", rdy35, rdy36);
        end
        checks++;
        if (res1 !== {12'sd3, -12'sd4, 12'sd3, -12'sd4, 2'b00}) begin
            failures++;
            $display("FAIL b2b_job1: got %h, want (3,-4) (3,-4) st=00", res1);
        end
        checks++;
        if (res2 !== {12'sd3, 12'sd0, 12'sd3, 12'sd0, 2'b00}) begin
            failures++;
            $display("FAIL b2b_job2: got %h, want (3,0) (3,0) st=00", res2);
        end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_no_queue: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_sqrt();
        int lat, seen;
        set_job(3, 5, 1, 0, 0, 5, 6, 0, 5, 1'b0);
        offer();
        repeat (11) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
            {out_x1, out_y1, out_x2, out_y2, out_status} !== '0) begin
            failures++;
            $display("FAIL midrst_state: out_valid=%b in_ready=%b (%0d,%0d) (%0d,%0d) st=%b, want 0 1 zeros",
                     out_valid, in_ready, out_x1, out_y1, out_x2, out_y2, out_status);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_quiet: out_valid seen %0d times, in_ready=%b, want 0 and 1", seen, in_ready);
        end
        offer();
        wait_done(lat);
        checks++;
        if (lat !== 34 || {out_x1, out_y1, out_x2, out_y2, out_status} !== {12'sd3, 12'sd4, 12'sd3, -12'sd4, 2'b00}) begin
            failures++;
            $display("FAIL midrst_next_job: lat=%0d (%0d,%0d) (%0d,%0d) st=%b, want 34 (3,4) (3,-4) st=00",
                     lat, out_x1, out_y1, out_x2, out_y2, out_status);
        end
        handoff();
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_no_intersect();
        test_tangent();
        test_degenerate();
        test_back_pressure();
        test_back_to_back();
        test_reset_mid_sqrt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
